bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 7 +
 rtl/bus_arbiter_prio_pick.sv | 15 +
 rtl/bus_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared FSM encoding and master index constants for the bus arbiter.
package bus_arbiter_pkg;
    typedef enum logic {IDLE = 1'b0, WAIT_RESP = 1'b1} state_t;
    localparam logic [1:0] MST_DBG = 2'd0;
    localparam logic [1:0] MST_LSU = 2'd1;
    localparam logic [1:0] MST_IFU = 2'd2;
endpackage

// File: rtl/bus_arbiter_prio_pick.sv
// arb_prio_pick: combinational winner selection, fixed priority m0 > m1 > m2
// unless the starvation override hands the bus to a requesting m2.
module arb_prio_pick
    import bus_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic       starve,
    output logic       any,
    output logic [1:0] winner
);
    assign any    = |req;
    assign winner = (starve && req[2]) ? MST_IFU :
                    req[0]             ? MST_DBG :
                    req[1]             ? MST_LSU : MST_IFU;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: three-master to single-port memory arbiter with starvation
// protection for instruction fetch and a response timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wstrb_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wstrb_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    input  logic        m2_req_i,
    input  logic        m2_we_i,
    input  logic [31:0] m2_addr_i,
    input  logic [31:0] m2_wdata_i,
    input  logic [3:0]  m2_wstrb_i,
    output logic        m2_gnt_o,
    output logic        m2_rvalid_o,
    output logic [31:0] m2_rdata_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_wstrb_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    output logic        hold_flag_o,
    output logic        err_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state, state_next;
    logic [1:0]      owner, winner;
    logic [SW-1:0]   scnt;
    logic [TW-1:0]   tcnt;
    logic            any, starve, idle_req, grant, in_wait, timeout, resp;

    arb_prio_pick u_pick (
        .req    ({m2_req_i, m1_req_i, m0_req_i}),
        .starve (starve),
        .any    (any),
        .winner (winner)
    );

    // Every output is gated by rst so all of them read 0 while reset is held.
    assign starve   = scnt == SW'(STARVE_LIMIT);
    assign idle_req = rst && state == IDLE && any;
    assign grant    = idle_req && s_gnt_i;
    assign in_wait  = rst && state == WAIT_RESP;
    assign timeout  = in_wait && !s_rvalid_i && tcnt == TW'(TIMEOUT - 1);
    assign resp     = in_wait && (s_rvalid_i || timeout);

    assign s_req_o   = idle_req;
    assign s_we_o    = idle_req && (winner == MST_IFU ? m2_we_i : winner == MST_LSU ? m1_we_i : m0_we_i);
    assign s_addr_o  = !idle_req ? '0 : winner == MST_IFU ? m2_addr_i : winner == MST_LSU ? m1_addr_i : m0_addr_i;
    assign s_wdata_o = !idle_req ? '0 : winner == MST_IFU ? m2_wdata_i : winner == MST_LSU ? m1_wdata_i : m0_wdata_i;
    assign s_wstrb_o = !idle_req ? '0 : winner == MST_IFU ? m2_wstrb_i : winner == MST_LSU ? m1_wstrb_i : m0_wstrb_i;

    assign m0_gnt_o = grant && winner == MST_DBG;
    assign m1_gnt_o = grant && winner == MST_LSU;
    assign m2_gnt_o = grant && winner == MST_IFU;

    assign m0_rvalid_o = resp && owner == MST_DBG;
    assign m1_rvalid_o = resp && owner == MST_LSU;
    assign m2_rvalid_o = resp && owner == MST_IFU;

    // A timed-out response leaves rdata at 0 because s_rvalid_i is low then.
    assign m0_rdata_o = (m0_rvalid_o && s_rvalid_i) ? s_rdata_i : '0;
    assign m1_rdata_o = (m1_rvalid_o && s_rvalid_i) ? s_rdata_i : '0;
    assign m2_rdata_o = (m2_rvalid_o && s_rvalid_i) ? s_rdata_i : '0;

    assign hold_flag_o = rst && m2_req_i && !m2_gnt_o;
    assign err_o       = timeout;

    always_comb begin
        state_next = state;
        if (grant)
            state_next = WAIT_RESP;
        else if (resp)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= MST_DBG;
            scnt  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner <= winner;
                tcnt  <= '0;
            end else if (in_wait) begin
                tcnt <= tcnt + 1'b1;
            end
            scnt <= (!m2_req_i || m2_gnt_o) ? '0 : (grant && !starve) ? scnt + 1'b1 : scnt;
        end
    end
endmodule
